// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: FSM states, queue entry layout and default sizing.
package sb_pkg;

    localparam int SB_DEPTH  = 4;
    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;
    localparam int SB_PTR_W  = $clog2(SB_DEPTH);

    typedef enum logic [0:0] {
        SB_RUN   = 1'b0,
        SB_FLUSH = 1'b1
    } sb_state_e;

    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// MEM-stage and data-memory signal bundle of the store buffer; slave is the buffer's view.
interface store_buffer_if #(
    parameter int ADDR_W = sb_pkg::SB_ADDR_W,
    parameter int DATA_W = sb_pkg::SB_DATA_W,
    parameter int CNT_W  = sb_pkg::SB_PTR_W + 1
) ();

    logic              SB_st_valid;
    logic [ADDR_W-1:0] SB_st_addr;
    logic [DATA_W-1:0] SB_st_data;
    logic              SB_st_ready;
    logic              SB_ld_valid;
    logic [ADDR_W-1:0] SB_ld_addr;
    logic [DATA_W-1:0] SB_ld_data;
    logic              SB_ld_stall;
    logic              SB_flush;
    logic              SB_flush_done;
    logic              SB_empty;
    logic [CNT_W-1:0]  SB_count;
    logic [ADDR_W-1:0] SB_mem_address;
    logic [DATA_W-1:0] SB_mem_data_in;
    logic              SB_mem_write;
    logic              SB_mem_read;
    logic [DATA_W-1:0] SB_mem_data_out;

    modport master (
        output SB_st_valid, SB_st_addr, SB_st_data, SB_ld_valid, SB_ld_addr, SB_flush,
               SB_mem_data_out,
        input  SB_st_ready, SB_ld_data, SB_ld_stall, SB_flush_done, SB_empty, SB_count,
               SB_mem_address, SB_mem_data_in, SB_mem_write, SB_mem_read
    );

    modport slave (
        input  SB_st_valid, SB_st_addr, SB_st_data, SB_ld_valid, SB_ld_addr, SB_flush,
               SB_mem_data_out,
        output SB_st_ready, SB_ld_data, SB_ld_stall, SB_flush_done, SB_empty, SB_count,
               SB_mem_address, SB_mem_data_in, SB_mem_write, SB_mem_read
    );

endinterface

// File: rtl/store_buffer_fwd_match.sv
// Load-address match over the queued stores: youngest exact hit plus any partial word overlap.
module sb_fwd_match
    import sb_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  sb_entry_t         entries [DEPTH],
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [PTR_W-1:0]  head,
    output logic              hit,
    output logic [PTR_W-1:0]  hit_idx,
    output logic              overlap
);

    function automatic logic words_overlap(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        logic [ADDR_W:0] a_ext;
        logic [ADDR_W:0] b_ext;
        a_ext = {1'b0, a};
        b_ext = {1'b0, b};
        return (a_ext < b_ext + (ADDR_W+1)'(4)) && (b_ext < a_ext + (ADDR_W+1)'(4));
    endfunction

    // Walking down from head-1 skips the free slots first, so the first valid hit is the youngest.
    always_comb begin
        logic [PTR_W-1:0] idx;
        hit     = 1'b0;
        hit_idx = '0;
        overlap = 1'b0;
        idx     = '0;
        for (int i = 1; i <= DEPTH; i++) begin
            idx = head - PTR_W'(i);
            if (entries[idx].valid) begin
                if (entries[idx].addr == ld_addr) begin
                    if (!hit) begin
                        hit     = 1'b1;
                        hit_idx = idx;
                    end
                end else if (words_overlap(entries[idx].addr, ld_addr)) begin
                    overlap = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: posted-write FIFO owning the data-memory port, with load forwarding and flush.
// Build macro SB_COALESCE_EN merges a store into the youngest entry when the addresses match.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic          clk,
    input  logic          rst_n,
    store_buffer_if.slave sb
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_state_e         state;
    sb_state_e         state_next;
    logic              flush_done_q;
    logic              flush_done_next;

    sb_entry_t         entries [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;

    logic              full;
    logic              empty;
    logic              st_ready;
    logic              push;
    logic              merge;
    logic              alloc;
    logic              pop;

    logic              hit;
    logic              overlap;
    logic [PTR_W-1:0]  hit_idx;

    logic              drain;
    logic              mem_rd;
    logic              mem_wr;
    logic              ld_stall;
    logic [DATA_W-1:0] ld_data;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign st_ready = !full && (state == SB_RUN);
    assign push     = sb.SB_st_valid && st_ready;

    sb_fwd_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fwd_match (
        .entries (entries),
        .ld_addr (sb.SB_ld_addr),
        .head    (head),
        .hit     (hit),
        .hit_idx (hit_idx),
        .overlap (overlap)
    );

    // Port arbitration: a missing load owns the port unless the queue is full or must drain.
    always_comb begin
        drain    = 1'b0;
        mem_rd   = 1'b0;
        ld_stall = 1'b0;
        ld_data  = sb.SB_mem_data_out;
        if (state == SB_FLUSH) begin
            drain    = !empty;
            ld_stall = sb.SB_ld_valid;
        end else if (!sb.SB_ld_valid) begin
            drain = !empty;
        end else if (hit) begin
            drain   = !empty;
            ld_data = entries[hit_idx].data;
        end else if (overlap || full) begin
            ld_stall = 1'b1;
            drain    = 1'b1;
        end else begin
            mem_rd = 1'b1;
        end
    end

    // The reset cycle must not write memory even though the head is still presented.
    assign mem_wr = drain && rst_n;
    assign pop    = mem_wr;

`ifdef SB_COALESCE_EN
    logic [PTR_W-1:0] youngest;
    assign youngest = tail - PTR_W'(1);
    assign merge    = push && entries[youngest].valid
                      && (entries[youngest].addr == sb.SB_st_addr)
                      && !(pop && (youngest == head));
`else
    assign merge = 1'b0;
`endif

    assign alloc      = push && !merge;
    assign count_next = count + CNT_W'(alloc) - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else begin
            if (pop) begin
                entries[head].valid <= 1'b0;
                head                <= head + PTR_W'(1);
            end
            if (alloc) begin
                entries[tail] <= '{valid: 1'b1, addr: sb.SB_st_addr, data: sb.SB_st_data};
                tail          <= tail + PTR_W'(1);
            end
`ifdef SB_COALESCE_EN
            if (merge) begin
                entries[youngest].data <= sb.SB_st_data;
            end
`endif
            count <= count_next;
        end
    end

    // Memory address/data hold their last driven value while the port idles.
    always_ff @(posedge clk) begin
        if (mem_wr || mem_rd) begin
            mem_addr_q <= sb.SB_mem_address;
        end
        if (mem_wr) begin
            mem_wdata_q <= sb.SB_mem_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= SB_RUN;
            flush_done_q <= 1'b0;
        end else begin
            state        <= state_next;
            flush_done_q <= flush_done_next;
        end
    end

    always_comb begin
        state_next      = state;
        flush_done_next = 1'b0;
        case (state)
            SB_RUN: begin
                if (sb.SB_flush) begin
                    if (count_next == '0) begin
                        flush_done_next = 1'b1;
                    end else begin
                        state_next = SB_FLUSH;
                    end
                end
            end
            SB_FLUSH: begin
                if (count_next == '0) begin
                    state_next      = SB_RUN;
                    flush_done_next = 1'b1;
                end
            end
            default: state_next = SB_RUN;
        endcase
    end

    assign sb.SB_st_ready     = st_ready;
    assign sb.SB_ld_stall     = ld_stall;
    assign sb.SB_ld_data      = ld_data;
    assign sb.SB_flush_done   = flush_done_q;
    assign sb.SB_empty        = empty;
    assign sb.SB_count        = count;
    assign sb.SB_mem_write    = mem_wr;
    assign sb.SB_mem_read     = mem_rd;
    assign sb.SB_mem_address  = mem_wr ? entries[head].addr : (mem_rd ? sb.SB_ld_addr : mem_addr_q);
    assign sb.SB_mem_data_in  = mem_wr ? entries[head].data : mem_wdata_q;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: queue-based reference model checked every cycle plus literal pins.
module tb_store_buffer;
    import sb_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    store_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (bus.slave)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, write captured on the falling edge.
    logic [31:0] mem [256];
    assign bus.SB_mem_data_out = mem[bus.SB_mem_address[9:2]];
    always @(negedge clk) begin
        if (bus.SB_mem_write) mem[bus.SB_mem_address[9:2]] = bus.SB_mem_data_in;
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mmem [256];
    bit          flushing  = 1'b0;
    bit          done_exp  = 1'b0;
    bit          last_ok   = 1'b0;
    bit          model_ok  = 1'b0;
    logic [31:0] last_addr = '0;
    int          n_checks  = 0;
    int          n_err     = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_cycle();
        int          cnt;
        bit          full;
        bit          ldv;
        logic [31:0] la;
        int          hit;
        bit          ovl;
        bit          drain;
        bit          rd;
        bit          wr;
        bit          stall;
        bit          merge;
        bit          accept;
        bit          go_flush;
        logic [31:0] ldd;
        cnt   = mq.size();
        full  = (cnt == DEPTH);
        ldv   = bus.SB_ld_valid;
        la    = bus.SB_ld_addr;
        hit   = -1;
        ovl   = 1'b0;
        drain = 1'b0;
        rd    = 1'b0;
        stall = 1'b0;
        merge = 1'b0;
        ldd   = '0;
        for (int i = 0; i < cnt; i++) begin
            if (mq[i].addr == la) hit = i;
            else if ((longint'(mq[i].addr) < longint'(la) + 4) && (longint'(la) < longint'(mq[i].addr) + 4)) ovl = 1'b1;
        end
        if (flushing) begin
            drain = (cnt > 0);
            stall = ldv;
        end else if (!ldv) begin
            drain = (cnt > 0);
        end else if (hit >= 0) begin
            drain = 1'b1;
            ldd   = mq[hit].data;
        end else if (ovl || full) begin
            stall = 1'b1;
            drain = 1'b1;
        end else begin
            rd  = 1'b1;
            ldd = mmem[la[9:2]];
        end
        wr = drain && rst_n;
        if (model_ok) begin
            chk("st_ready",   64'(bus.SB_st_ready),   64'(!full && !flushing));
            chk("ld_stall",   64'(bus.SB_ld_stall),   64'(stall));
            chk("mem_write",  64'(bus.SB_mem_write),  64'(wr));
            chk("mem_read",   64'(bus.SB_mem_read),   64'(rd));
            chk("count",      64'(bus.SB_count),      64'(cnt));
            chk("empty",      64'(bus.SB_empty),      64'(cnt == 0));
            chk("flush_done", 64'(bus.SB_flush_done), 64'(done_exp));
            if (wr) begin
                chk("wr_addr", 64'(bus.SB_mem_address), 64'(mq[0].addr));
                chk("wr_data", 64'(bus.SB_mem_data_in), 64'(mq[0].data));
            end else if (rd) begin
                chk("rd_addr", 64'(bus.SB_mem_address), 64'(la));
            end else if (last_ok) begin
                chk("hold_addr", 64'(bus.SB_mem_address), 64'(last_addr));
            end
            if (ldv && !stall) chk("ld_data", 64'(bus.SB_ld_data), 64'(ldd));
        end
        if (wr || rd) begin
            last_addr = wr ? mq[0].addr : la;
            last_ok   = 1'b1;
        end
        if (!rst_n) begin
            mq.delete();
            flushing = 1'b0;
            done_exp = 1'b0;
            model_ok = 1'b1;
        end else begin
            accept   = bus.SB_st_valid && !full && !flushing;
            go_flush = flushing || bus.SB_flush;
`ifdef SB_COALESCE_EN
            if (accept && cnt > 0 && mq[cnt-1].addr == bus.SB_st_addr && !(drain && cnt == 1)) merge = 1'b1;
`endif
            if (drain) begin
                mmem[mq[0].addr[9:2]] = mq[0].data;
                void'(mq.pop_front());
            end
            if (merge) mq[mq.size()-1].data = bus.SB_st_data;
            else if (accept) mq.push_back('{addr: bus.SB_st_addr, data: bus.SB_st_data});
            done_exp = go_flush && (mq.size() == 0);
            flushing = go_flush && (mq.size() != 0);
        end
    endtask

    always @(posedge clk) begin
        #4;
        model_cycle();
    end

    task automatic cyc(input bit sv, input logic [31:0] sa, input logic [31:0] sd,
                       input bit lv, input logic [31:0] la, input bit fl, input bit rn);
        @(posedge clk);
        #1;
        bus.SB_st_valid = sv;
        bus.SB_st_addr  = sa;
        bus.SB_st_data  = sd;
        bus.SB_ld_valid = lv;
        bus.SB_ld_addr  = la;
        bus.SB_flush    = fl;
        rst_n           = rn;
        #2;
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]  = '0;
            mmem[i] = '0;
        end
        bus.SB_st_valid = 1'b0;
        bus.SB_st_addr  = '0;
        bus.SB_st_data  = '0;
        bus.SB_ld_valid = 1'b0;
        bus.SB_ld_addr  = '0;
        bus.SB_flush    = 1'b0;

        cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        idle();
        chk("rst_count",      64'(bus.SB_count),      64'd0);
        chk("rst_empty",      64'(bus.SB_empty),      64'd1);
        chk("rst_flush_done", 64'(bus.SB_flush_done), 64'd0);
        chk("rst_st_ready",   64'(bus.SB_st_ready),   64'd1);

        // Single store drains the following cycle and is then readable from memory.
        cyc(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b1);
        idle();
        chk("t1_write", 64'(bus.SB_mem_write),   64'd1);
        chk("t1_addr",  64'(bus.SB_mem_address), 64'h10);
        chk("t1_data",  64'(bus.SB_mem_data_in), 64'hDEADBEEF);
        idle();
        chk("t1_empty", 64'(bus.SB_empty), 64'd1);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h10, 1'b0, 1'b1);
        chk("t1_read",    64'(bus.SB_mem_read), 64'd1);
        chk("t1_ld_data", 64'(bus.SB_ld_data),  64'hDEADBEEF);

        // Fill behind back-to-back missing loads; the full queue forces one stalled drain.
        for (int k = 0; k < 4; k++) cyc(1'b1, 32'h40 + 32'(4*k), 32'hA0 + 32'(k), 1'b1, 32'h80, 1'b0, 1'b1);
        cyc(1'b1, 32'h50, 32'hBB, 1'b1, 32'h80, 1'b0, 1'b1);
        chk("t2_count",    64'(bus.SB_count),       64'd4);
        chk("t2_st_ready", 64'(bus.SB_st_ready),    64'd0);
        chk("t2_stall",    64'(bus.SB_ld_stall),    64'd1);
        chk("t2_drain",    64'(bus.SB_mem_address), 64'h40);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h80, 1'b0, 1'b1);
        chk("t2_unstall",  64'(bus.SB_ld_stall),    64'd0);
        chk("t2_read",     64'(bus.SB_mem_read),    64'd1);
        repeat (3) idle();

        // Two stores to one address: the load must see the younger value without a memory read.
        cyc(1'b1, 32'h20, 32'h11111111, 1'b1, 32'h80, 1'b0, 1'b1);
        cyc(1'b1, 32'h20, 32'h22222222, 1'b1, 32'h80, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h20, 1'b0, 1'b1);
        chk("t3_ld_data", 64'(bus.SB_ld_data),  64'h22222222);
        chk("t3_no_read", 64'(bus.SB_mem_read), 64'd0);
        repeat (2) idle();

        // Partial overlap stalls until the entry drains, then the load reads memory.
        cyc(1'b1, 32'h20, 32'h33333333, 1'b1, 32'h80, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h22, 1'b0, 1'b1);
        chk("t4_stall",   64'(bus.SB_ld_stall),  64'd1);
        chk("t4_write",   64'(bus.SB_mem_write), 64'd1);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h22, 1'b0, 1'b1);
        chk("t4_unstall", 64'(bus.SB_ld_stall),  64'd0);
        chk("t4_ld_data", 64'(bus.SB_ld_data),   64'h33333333);

        // Flush of three entries: in-order writes, done pulse in the fourth cycle.
        for (int k = 0; k < 3; k++) cyc(1'b1, 32'h50 + 32'(4*k), 32'h5000 + 32'(k), 1'b1, 32'h80, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("t5_addr0", 64'(bus.SB_mem_address), 64'h50);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h80, 1'b0, 1'b1);
        chk("t5_addr1",  64'(bus.SB_mem_address), 64'h54);
        chk("t5_ready1", 64'(bus.SB_st_ready),    64'd0);
        chk("t5_stall",  64'(bus.SB_ld_stall),    64'd1);
        idle();
        chk("t5_addr2",  64'(bus.SB_mem_data_in), 64'h5002);
        chk("t5_ready2", 64'(bus.SB_st_ready),    64'd0);
        idle();
        chk("t5_done",   64'(bus.SB_flush_done),  64'd1);
        idle();
        chk("t5_done_low", 64'(bus.SB_flush_done), 64'd0);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        idle();
        chk("t5_empty_done", 64'(bus.SB_flush_done), 64'd1);

        // Reset with entries pending discards them without writing.
        cyc(1'b1, 32'h60, 32'h66, 1'b1, 32'h80, 1'b0, 1'b1);
        cyc(1'b1, 32'h64, 32'h67, 1'b1, 32'h80, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("t6_no_write", 64'(bus.SB_mem_write), 64'd0);
        idle();
        chk("t6_count", 64'(bus.SB_count), 64'd0);
        chk("t6_empty", 64'(bus.SB_empty), 64'd1);

        cyc(1'b1, 32'h30, 32'h1, 1'b1, 32'h80, 1'b0, 1'b1);
        cyc(1'b1, 32'h30, 32'h2, 1'b1, 32'h80, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h80, 1'b0, 1'b1);
`ifdef SB_COALESCE_EN
        chk("t6_coalesce_count", 64'(bus.SB_count), 64'd1);
`else
        chk("t6_alloc_count", 64'(bus.SB_count), 64'd2);
`endif
        repeat (3) idle();
        chk("mem_0x10", 64'(mem[8'h04]), 64'hDEADBEEF);
        chk("mem_0x30", 64'(mem[8'h0C]), 64'h2);
        chk("mem_0x60", 64'(mem[8'h18]), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
